// File: rtl/rv_isa_pkg.sv
// RV32IM opcode map, immediate format classes and the decoded-field payload
// shared by the decode stage and its field extractor.
package rv_isa_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_ILL
    } imm_fmt_e;

    typedef struct packed {
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [11:0] imm12;
        logic [19:0] imm20;
        logic        imm_ctrl;
        logic        jal;
        logic        branch;
        logic        illegal;
    } dec_fields_t;

    function automatic imm_fmt_e opc_fmt(input logic [6:0] opc);
        case (opc)
            OPC_LOAD, OPC_OPIMM, OPC_JALR, OPC_SYSTEM: return FMT_I;
            OPC_STORE:                                 return FMT_S;
            OPC_BRANCH:                                return FMT_B;
            OPC_LUI, OPC_AUIPC:                        return FMT_U;
            OPC_JAL:                                   return FMT_J;
            OPC_OP, OPC_FENCE:                         return FMT_R;
            default:                                   return FMT_ILL;
        endcase
    endfunction

endpackage

// File: rtl/rv_inst_fields.sv
// Purpose: slices a raw instruction word into register indices, functs and raw immediates.
// Latency: combinational.
// Backpressure: none, pure function of instr.
module rv_inst_fields
    import rv_isa_pkg::*;
(
    input  logic [31:0]  instr,
    output dec_fields_t  fields
);

    always_comb begin
        fields        = '0;
        fields.opcode = instr[6:0];
        fields.rd     = instr[11:7];
        fields.funct3 = instr[14:12];
        fields.rs1    = instr[19:15];
        fields.rs2    = instr[24:20];
        fields.funct7 = instr[31:25];
        case (opc_fmt(instr[6:0]))
            FMT_I: fields.imm12 = instr[31:20];
            FMT_S: fields.imm12 = {instr[31:25], instr[11:7]};
            FMT_B: begin
                fields.imm12  = {instr[31], instr[7], instr[30:25], instr[11:8]};
                fields.branch = 1'b1;
            end
            FMT_U: begin
                fields.imm20    = instr[31:12];
                fields.imm_ctrl = 1'b1;
            end
            FMT_J: begin
                fields.imm20    = {instr[31], instr[19:12], instr[20], instr[30:21]};
                fields.imm_ctrl = 1'b1;
                fields.jal      = 1'b1;
            end
            FMT_ILL: fields.illegal = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// Purpose: IF/ID register with decode-before-register and a one-entry skid buffer.
// Latency: 1 cycle from upstream acceptance to id_valid.
// Backpressure: if_ready is the registered inverse of skid occupancy; full rate when id_ready=1.
module decode_stage
    import rv_isa_pkg::*;
#(
    parameter int               XLEN         = 32,
    parameter logic [XLEN-1:0]  RESET_PC_TAG = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            if_valid,
    output logic            if_ready,
    input  logic [XLEN-1:0] if_pc,
    input  logic [XLEN-1:0] if_instr,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [XLEN-1:0] id_pc,
    output logic [6:0]      id_opcode,
    output logic [4:0]      id_rd,
    output logic [4:0]      id_rs1,
    output logic [4:0]      id_rs2,
    output logic [2:0]      id_funct3,
    output logic [6:0]      id_funct7,
    output logic [11:0]     id_imm12,
    output logic [19:0]     id_imm20,
    output logic            id_imm_ctrl,
    output logic            id_jal,
    output logic            id_branch,
    output logic            id_illegal
);

    dec_fields_t     in_dat;
    dec_fields_t     or_dat;
    dec_fields_t     sk_dat;
    logic [XLEN-1:0] or_pc;
    logic [XLEN-1:0] sk_pc;
    logic            or_vld;
    logic            sk_vld;
    logic            accept;
    logic            or_load_en;

    rv_inst_fields u_fields (
        .instr  (if_instr[31:0]),
        .fields (in_dat)
    );

    assign accept     = if_valid & ~sk_vld;
    assign or_load_en = ~or_vld | id_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            or_vld <= 1'b0;
            sk_vld <= 1'b0;
            or_dat <= '0;
            sk_dat <= '0;
            or_pc  <= RESET_PC_TAG;
            sk_pc  <= RESET_PC_TAG;
        end else if (flush) begin
            or_vld <= 1'b0;
            sk_vld <= 1'b0;
        end else if (sk_vld) begin
            // Fetch is stalled while the skid is occupied, so only the skid can refill OR.
            if (or_load_en) begin
                or_dat <= sk_dat;
                or_pc  <= sk_pc;
                or_vld <= 1'b1;
                sk_vld <= 1'b0;
            end
        end else if (accept) begin
            if (or_load_en) begin
                or_dat <= in_dat;
                or_pc  <= if_pc;
                or_vld <= 1'b1;
            end else begin
                sk_dat <= in_dat;
                sk_pc  <= if_pc;
                sk_vld <= 1'b1;
            end
        end else if (or_load_en) begin
            or_vld <= 1'b0;
        end
    end

    assign if_ready    = ~sk_vld;
    assign id_valid    = or_vld;
    assign id_pc       = or_vld ? or_pc : RESET_PC_TAG;
    assign id_opcode   = or_dat.opcode;
    assign id_rd       = or_dat.rd;
    assign id_rs1      = or_dat.rs1;
    assign id_rs2      = or_dat.rs2;
    assign id_funct3   = or_dat.funct3;
    assign id_funct7   = or_dat.funct7;
    assign id_imm12    = or_dat.imm12;
    assign id_imm20    = or_dat.imm20;
    assign id_imm_ctrl = or_dat.imm_ctrl;
    assign id_jal      = or_dat.jal;
    assign id_branch   = or_dat.branch;
    assign id_illegal  = or_dat.illegal;

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- IF/ID pipeline stage of the RV32IM core, directly upstream of the immediate sign extender.
- Accepts fetched instruction/PC pairs over a valid/ready handshake and registers the decoded fields: rd, rs1, rs2, funct3, funct7, opcode, raw immediate fields and immediate-select flags.
- Fields go to the sign extender, register file and control unit.
- Contains a one-entry skid buffer so that both if_ready and id_valid are register-driven.

Parameters:
- XLEN, 32, instruction and PC width.
- RESET_PC_TAG, 32'h0000_0000, value driven on id_pc while id_valid=0 and after reset.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  discard all held and incoming instructions (branch/jump redirect).
- if_valid  in  1  fetch presents an instruction.
- if_ready  out  1  stage can accept.
- if_pc  in  XLEN  PC of the instruction.
- if_instr  in  XLEN  raw instruction word.
- id_valid  out  1  decoded outputs valid.
- id_ready  in  1  downstream accepts.
- id_pc  out  XLEN  PC of the decoded instruction.
- id_opcode  out  7  instr[6:0].
- id_rd, id_rs1, id_rs2  out  5 each  register indices.
- id_funct3  out  3  instr[14:12].
- id_funct7  out  7  instr[31:25].
- id_imm12  out  12  12-bit immediate field.
- id_imm20  out  20  20-bit immediate field.
- id_imm_ctrl  out  1  0 selects imm12, 1 selects imm20 (sign-extender control).
- id_jal  out  1  imm20 is a J-type offset[20:1] (sign extender shifts by 1).
- id_branch  out  1  imm12 is a B-type offset[12:1].
- id_illegal  out  1  unsupported opcode.

Behaviour:
- Reset (async assert, sync release):
  - id_valid=0, if_ready=1, skid empty.
  - All id_* data outputs 0, except id_pc=RESET_PC_TAG.
- Transfers:
  - Upstream transfer when if_valid & if_ready.
  - Downstream transfer when id_valid & id_ready.
- Latency: 1 cycle. An instruction accepted at edge N is visible on id_* after edge N.
- Output register (OR):
  - Loads when empty, or when its current contents transfer this cycle.
  - Source is the skid entry if occupied, otherwise the incoming instruction.
- Skid buffer (SK):
  - Captures the incoming instruction when it is accepted while OR holds data and id_ready=0.
  - if_ready = ~SK_valid (registered).
  - When SK is occupied and OR drains, SK moves to OR and SK clears. The incoming instruction is not accepted that cycle.
- Ordering: strictly in order, no duplication, no loss.
- Back-to-back throughput is 1 instruction/cycle when id_ready=1.
- Flush (synchronous, highest priority):
  - Next cycle id_valid=0 and SK empty.
  - An instruction presented in the same cycle is dropped.
  - if_ready=1 the following cycle.
- Decode is applied before registering; the skid entry stores decoded fields.
- Immediate formats:
  - I-type (0000011, 0010011, 1100111, 1110011): imm12=instr[31:20], ctrl=0, jal=0.
  - S-type (0100011): imm12={instr[31:25],instr[11:7]}, ctrl=0.
  - B-type (1100011): imm12={instr[31],instr[7],instr[30:25],instr[11:8]}, ctrl=0, branch=1.
  - U-type (0110111, 0010111): imm20=instr[31:12], ctrl=1, jal=0.
  - J-type (1101111): imm20={instr[31],instr[19:12],instr[20],instr[30:21]}, ctrl=1, jal=1.
  - R-type (0110011, incl. M-extension funct7=0000001) and FENCE (0001111): imm fields 0, ctrl=0.
  - Any other opcode: id_illegal=1, imm fields 0, flags 0. The instruction still flows through the handshake.
  - Unused imm field for a format is driven 0.
- Register indices are always extracted from fixed bit positions regardless of format.
- Reset mid-operation: async clear of OR and SK; no partial transfers survive.

Decomposition:
- Shared package rv_isa_pkg holds:
  - Opcode localparams (OPC_LOAD, OPC_OPIMM, OPC_STORE, OPC_BRANCH, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_OP, OPC_FENCE, OPC_SYSTEM).
  - Enum imm_fmt_e {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_ILL}.
  - Packed struct dec_fields_t for the registered payload.
- One combinational sub-module, rv_inst_fields: instr in, dec_fields_t out. It is reused for both OR and SK loads.

Test Plan:
- 0xFFF00093 (addi x1,x0,-1), id_ready=1 -> next cycle:
  - id_valid=1, id_rd=1, id_rs1=0, id_imm12=0xFFF, id_imm_ctrl=0, id_jal=0, id_illegal=0.
- 0x001000EF (jal x1,+2048) -> id_imm20=0x00400, id_imm_ctrl=1, id_jal=1, id_rd=1.
- 0x123452B7 (lui x5,0x12345) -> id_imm20=0x12345, id_imm_ctrl=1, id_jal=0, id_rd=5.
- 0xFE21AE23 (sw x2,-4(x3)) -> id_imm12=0xFFC, id_rs1=3, id_rs2=2, id_funct3=2, id_imm_ctrl=0.
- Backpressure:
  - Stimulus: id_ready=0, three back-to-back instructions with PCs 0x0, 0x4, 0x8.
  - Required: if_ready falls after the second is accepted; PC 0x8 is held by fetch.
  - Required: once id_ready=1, id_pc sequence is 0x0, 0x4, 0x8 on consecutive cycles, no gaps or duplicates.
- Flush and reset:
  - Flush with OR and SK full -> next cycle id_valid=0, if_ready=1.
  - Opcode 0x7F -> id_illegal=1.
  - rst_n low mid-stream -> id_valid=0 immediately without waiting for a clock edge.
